// File: rtl/tl_pkg.sv
// Shared TileLink-UL field widths and channel payload structs.
package tl_pkg;

  localparam int unsigned TL_ADDR_W = 31;
  localparam int unsigned TL_DATA_W = 64;
  localparam int unsigned TL_SIZE_W = 4;
  localparam int unsigned TL_SRC_W  = 1;
  localparam int unsigned TL_SINK_W = 1;
  localparam int unsigned TL_MASK_W = TL_DATA_W / 8;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [2:0]           param;
    logic [TL_SIZE_W-1:0] size;
    logic [TL_SRC_W-1:0]  source;
    logic [TL_ADDR_W-1:0] address;
    logic [TL_MASK_W-1:0] mask;
    logic [TL_DATA_W-1:0] data;
    logic                 corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [1:0]           param;
    logic [TL_SIZE_W-1:0] size;
    logic [TL_SRC_W-1:0]  source;
    logic [TL_SINK_W-1:0] sink;
    logic                 denied;
    logic [TL_DATA_W-1:0] data;
    logic                 corrupt;
  } tl_d_t;

  localparam int unsigned TL_A_W = $bits(tl_a_t);
  localparam int unsigned TL_D_W = $bits(tl_d_t);

endpackage

// File: rtl/tl_queue.sv
// Small FIFO with registered state; ready and valid come straight from flops, so no
// input reaches an output combinationally. Depth must be a power of two >= 2.
module tl_queue #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enq_valid_i,
  output logic             enq_ready_o,
  input  logic [Width-1:0] enq_data_i,
  output logic             deq_valid_o,
  input  logic             deq_ready_i,
  output logic [Width-1:0] deq_data_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic             maybe_full_q, maybe_full_d;
  logic             ptr_match, empty, full, enq_fire, deq_fire;

  assign ptr_match   = (wr_ptr_q == rd_ptr_q);
  assign empty       = ptr_match & ~maybe_full_q;
  assign full        = ptr_match & maybe_full_q;
  assign enq_ready_o = ~full;
  assign deq_valid_o = ~empty;
  assign deq_data_o  = mem_q[rd_ptr_q];
  assign enq_fire    = enq_valid_i & ~full;
  assign deq_fire    = deq_ready_i & ~empty;

  // Pointer and occupancy-flag next state; pointers wrap naturally at Depth.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    maybe_full_d = maybe_full_q;
    if (enq_fire) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (deq_fire) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (enq_fire != deq_fire) maybe_full_d = enq_fire;
  end

  // Control state; reset discards any buffered entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      maybe_full_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      maybe_full_q <= maybe_full_d;
    end
  end

  // Storage is not reset; contents are only observed while valid.
  always_ff @(posedge clk_i) begin
    if (enq_fire) mem_q[wr_ptr_q] <= enq_data_i;
  end

endmodule

// File: rtl/tl_buffer_2.sv
// Two-channel TileLink-UL buffer: A toward the slave, D back toward the coupler.
module tl_buffer_2
  import tl_pkg::*;
#(
  parameter int unsigned A_DEPTH = 2,
  parameter int unsigned D_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 auto_in_a_valid,
  output logic                 auto_in_a_ready,
  input  logic [2:0]           auto_in_a_bits_opcode,
  input  logic [2:0]           auto_in_a_bits_param,
  input  logic [TL_SIZE_W-1:0] auto_in_a_bits_size,
  input  logic [TL_SRC_W-1:0]  auto_in_a_bits_source,
  input  logic [TL_ADDR_W-1:0] auto_in_a_bits_address,
  input  logic [TL_MASK_W-1:0] auto_in_a_bits_mask,
  input  logic [TL_DATA_W-1:0] auto_in_a_bits_data,
  input  logic                 auto_in_a_bits_corrupt,
  output logic                 auto_out_a_valid,
  input  logic                 auto_out_a_ready,
  output logic [2:0]           auto_out_a_bits_opcode,
  output logic [2:0]           auto_out_a_bits_param,
  output logic [TL_SIZE_W-1:0] auto_out_a_bits_size,
  output logic [TL_SRC_W-1:0]  auto_out_a_bits_source,
  output logic [TL_ADDR_W-1:0] auto_out_a_bits_address,
  output logic [TL_MASK_W-1:0] auto_out_a_bits_mask,
  output logic [TL_DATA_W-1:0] auto_out_a_bits_data,
  output logic                 auto_out_a_bits_corrupt,
  input  logic                 auto_out_d_valid,
  output logic                 auto_out_d_ready,
  input  logic [2:0]           auto_out_d_bits_opcode,
  input  logic [1:0]           auto_out_d_bits_param,
  input  logic [TL_SIZE_W-1:0] auto_out_d_bits_size,
  input  logic [TL_SRC_W-1:0]  auto_out_d_bits_source,
  input  logic [TL_SINK_W-1:0] auto_out_d_bits_sink,
  input  logic                 auto_out_d_bits_denied,
  input  logic [TL_DATA_W-1:0] auto_out_d_bits_data,
  input  logic                 auto_out_d_bits_corrupt,
  output logic                 auto_in_d_valid,
  input  logic                 auto_in_d_ready,
  output logic [2:0]           auto_in_d_bits_opcode,
  output logic [1:0]           auto_in_d_bits_param,
  output logic [TL_SIZE_W-1:0] auto_in_d_bits_size,
  output logic [TL_SRC_W-1:0]  auto_in_d_bits_source,
  output logic [TL_SINK_W-1:0] auto_in_d_bits_sink,
  output logic                 auto_in_d_bits_denied,
  output logic [TL_DATA_W-1:0] auto_in_d_bits_data,
  output logic                 auto_in_d_bits_corrupt
);

  tl_a_t a_enq, a_deq;
  tl_d_t d_enq, d_deq;

  assign a_enq = '{opcode: auto_in_a_bits_opcode, param: auto_in_a_bits_param,
                   size: auto_in_a_bits_size, source: auto_in_a_bits_source,
                   address: auto_in_a_bits_address, mask: auto_in_a_bits_mask,
                   data: auto_in_a_bits_data, corrupt: auto_in_a_bits_corrupt};

  assign d_enq = '{opcode: auto_out_d_bits_opcode, param: auto_out_d_bits_param,
                   size: auto_out_d_bits_size, source: auto_out_d_bits_source,
                   sink: auto_out_d_bits_sink, denied: auto_out_d_bits_denied,
                   data: auto_out_d_bits_data, corrupt: auto_out_d_bits_corrupt};

  assign auto_out_a_bits_opcode  = a_deq.opcode;
  assign auto_out_a_bits_param   = a_deq.param;
  assign auto_out_a_bits_size    = a_deq.size;
  assign auto_out_a_bits_source  = a_deq.source;
  assign auto_out_a_bits_address = a_deq.address;
  assign auto_out_a_bits_mask    = a_deq.mask;
  assign auto_out_a_bits_data    = a_deq.data;
  assign auto_out_a_bits_corrupt = a_deq.corrupt;

  assign auto_in_d_bits_opcode  = d_deq.opcode;
  assign auto_in_d_bits_param   = d_deq.param;
  assign auto_in_d_bits_size    = d_deq.size;
  assign auto_in_d_bits_source  = d_deq.source;
  assign auto_in_d_bits_sink    = d_deq.sink;
  assign auto_in_d_bits_denied  = d_deq.denied;
  assign auto_in_d_bits_data    = d_deq.data;
  assign auto_in_d_bits_corrupt = d_deq.corrupt;

  tl_queue #(
    .Depth (A_DEPTH),
    .Width (TL_A_W)
  ) u_a_queue (
    .clk_i       (clock),
    .rst_ni      (reset),
    .enq_valid_i (auto_in_a_valid),
    .enq_ready_o (auto_in_a_ready),
    .enq_data_i  (a_enq),
    .deq_valid_o (auto_out_a_valid),
    .deq_ready_i (auto_out_a_ready),
    .deq_data_o  (a_deq)
  );

  tl_queue #(
    .Depth (D_DEPTH),
    .Width (TL_D_W)
  ) u_d_queue (
    .clk_i       (clock),
    .rst_ni      (reset),
    .enq_valid_i (auto_out_d_valid),
    .enq_ready_o (auto_out_d_ready),
    .enq_data_i  (d_enq),
    .deq_valid_o (auto_in_d_valid),
    .deq_ready_i (auto_in_d_ready),
    .deq_data_o  (d_deq)
  );

endmodule

// File: tb/tb_tl_buffer_2.sv
// Bench for tl_buffer_2: per-cycle handshake vector table, scoreboard on both channels,
// and hand-written sequences for latency, streaming, wrap and mid-cycle reset.
module tb_tl_buffer_2;
  import tl_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic in_a_valid, in_a_ready, out_a_valid, out_a_ready;
  logic out_d_valid, out_d_ready, in_d_valid, in_d_ready;
  tl_a_t a_drv, a_mon;
  tl_d_t d_drv, d_mon;

  logic [2:0]           oa_opcode, oa_param;
  logic [TL_SIZE_W-1:0] oa_size;
  logic [TL_SRC_W-1:0]  oa_source;
  logic [TL_ADDR_W-1:0] oa_address;
  logic [TL_MASK_W-1:0] oa_mask;
  logic [TL_DATA_W-1:0] oa_data;
  logic                 oa_corrupt;
  logic [2:0]           id_opcode;
  logic [1:0]           id_param;
  logic [TL_SIZE_W-1:0] id_size;
  logic [TL_SRC_W-1:0]  id_source;
  logic [TL_SINK_W-1:0] id_sink;
  logic                 id_denied;
  logic [TL_DATA_W-1:0] id_data;
  logic                 id_corrupt;

  assign a_mon = {oa_opcode, oa_param, oa_size, oa_source, oa_address, oa_mask, oa_data,
                  oa_corrupt};
  assign d_mon = {id_opcode, id_param, id_size, id_source, id_sink, id_denied, id_data,
                  id_corrupt};

  int n_cmp = 0;
  int n_err = 0;
  int d_deq_cnt = 0;
  tl_a_t a_q[$];
  tl_d_t d_q[$];

  always #5 clock = ~clock;

  tl_buffer_2 #(
    .A_DEPTH (2),
    .D_DEPTH (2)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .auto_in_a_valid         (in_a_valid),
    .auto_in_a_ready         (in_a_ready),
    .auto_in_a_bits_opcode   (a_drv.opcode),
    .auto_in_a_bits_param    (a_drv.param),
    .auto_in_a_bits_size     (a_drv.size),
    .auto_in_a_bits_source   (a_drv.source),
    .auto_in_a_bits_address  (a_drv.address),
    .auto_in_a_bits_mask     (a_drv.mask),
    .auto_in_a_bits_data     (a_drv.data),
    .auto_in_a_bits_corrupt  (a_drv.corrupt),
    .auto_out_a_valid        (out_a_valid),
    .auto_out_a_ready        (out_a_ready),
    .auto_out_a_bits_opcode  (oa_opcode),
    .auto_out_a_bits_param   (oa_param),
    .auto_out_a_bits_size    (oa_size),
    .auto_out_a_bits_source  (oa_source),
    .auto_out_a_bits_address (oa_address),
    .auto_out_a_bits_mask    (oa_mask),
    .auto_out_a_bits_data    (oa_data),
    .auto_out_a_bits_corrupt (oa_corrupt),
    .auto_out_d_valid        (out_d_valid),
    .auto_out_d_ready        (out_d_ready),
    .auto_out_d_bits_opcode  (d_drv.opcode),
    .auto_out_d_bits_param   (d_drv.param),
    .auto_out_d_bits_size    (d_drv.size),
    .auto_out_d_bits_source  (d_drv.source),
    .auto_out_d_bits_sink    (d_drv.sink),
    .auto_out_d_bits_denied  (d_drv.denied),
    .auto_out_d_bits_data    (d_drv.data),
    .auto_out_d_bits_corrupt (d_drv.corrupt),
    .auto_in_d_valid         (in_d_valid),
    .auto_in_d_ready         (in_d_ready),
    .auto_in_d_bits_opcode   (id_opcode),
    .auto_in_d_bits_param    (id_param),
    .auto_in_d_bits_size     (id_size),
    .auto_in_d_bits_source   (id_source),
    .auto_in_d_bits_sink     (id_sink),
    .auto_in_d_bits_denied   (id_denied),
    .auto_in_d_bits_data     (id_data),
    .auto_in_d_bits_corrupt  (id_corrupt)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic tl_a_t rand_a();
    tl_a_t a;
    a.opcode  = 3'($urandom);
    a.param   = 3'($urandom);
    a.size    = 4'($urandom);
    a.source  = 1'($urandom);
    a.address = 31'($urandom);
    a.mask    = 8'($urandom);
    a.data    = {$urandom, $urandom};
    a.corrupt = 1'($urandom);
    return a;
  endfunction

  function automatic tl_d_t rand_d();
    tl_d_t d;
    d.opcode  = 3'($urandom);
    d.param   = 2'($urandom);
    d.size    = 4'($urandom);
    d.source  = 1'($urandom);
    d.sink    = 1'($urandom);
    d.denied  = 1'($urandom);
    d.data    = {$urandom, $urandom};
    d.corrupt = 1'($urandom);
    return d;
  endfunction

  // Scoreboard: samples mid-cycle, ahead of the edge where the handshakes fire. Pops happen
  // before pushes so a beat cannot be matched in the cycle it was accepted.
  always @(negedge clock) begin
    if (!reset) begin
      a_q.delete();
      d_q.delete();
    end else begin
      if (out_a_valid && out_a_ready) begin
        if (a_q.size() == 0) chk("a_unexpected_beat", 128'(a_mon), 128'hx);
        else chk("a_beat", 128'(a_mon), 128'(a_q.pop_front()));
      end
      if (in_d_valid && in_d_ready) begin
        d_deq_cnt++;
        if (d_q.size() == 0) chk("d_unexpected_beat", 128'(d_mon), 128'hx);
        else chk("d_beat", 128'(d_mon), 128'(d_q.pop_front()));
      end
      if (in_a_valid && in_a_ready) a_q.push_back(a_drv);
      if (out_d_valid && out_d_ready) d_q.push_back(d_drv);
    end
  end

  typedef struct {
    logic a_v, oa_r, d_v, id_r;        // drive
    logic e_oa_v, e_ia_r, e_id_v, e_od_r;  // expected before driving
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit   a_fire, d_fire;
    int   gaps, d_cnt0;
    tl_a_t a_single;

    reset       = 1'b0;
    in_a_valid  = 1'b0;
    out_a_ready = 1'b0;
    out_d_valid = 1'b0;
    in_d_ready  = 1'b0;
    a_drv       = rand_a();
    d_drv       = rand_d();

    // Backpressure fill to depth 2, third beat held, then drain in order.
    vecs[0] = '{1, 0, 1, 0, 0, 1, 0, 1};
    vecs[1] = '{1, 0, 1, 0, 1, 1, 1, 1};
    vecs[2] = '{1, 0, 1, 0, 1, 0, 1, 0};
    vecs[3] = '{1, 1, 1, 1, 1, 0, 1, 0};
    vecs[4] = '{1, 1, 1, 1, 1, 1, 1, 1};
    vecs[5] = '{0, 1, 0, 1, 1, 1, 1, 1};
    vecs[6] = '{0, 0, 0, 0, 0, 1, 0, 1};

    #2;
    chk("in_reset_out_a_valid", 128'(out_a_valid), 128'(0));
    chk("in_reset_in_a_ready", 128'(in_a_ready), 128'(1));
    chk("in_reset_in_d_valid", 128'(in_d_valid), 128'(0));
    chk("in_reset_out_d_ready", 128'(out_d_ready), 128'(1));
    #10 reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 7; i++) begin
      chk($sformatf("vec%0d_out_a_valid", i), 128'(out_a_valid), 128'(vecs[i].e_oa_v));
      chk($sformatf("vec%0d_in_a_ready", i), 128'(in_a_ready), 128'(vecs[i].e_ia_r));
      chk($sformatf("vec%0d_in_d_valid", i), 128'(in_d_valid), 128'(vecs[i].e_id_v));
      chk($sformatf("vec%0d_out_d_ready", i), 128'(out_d_ready), 128'(vecs[i].e_od_r));
      in_a_valid  = vecs[i].a_v;
      out_a_ready = vecs[i].oa_r;
      out_d_valid = vecs[i].d_v;
      in_d_ready  = vecs[i].id_r;
      a_fire = in_a_valid && in_a_ready;
      d_fire = out_d_valid && out_d_ready;
      @(posedge clock); #1;
      if (a_fire) a_drv = rand_a();
      if (d_fire) d_drv = rand_d();
    end

    // Single A beat with fixed fields: visible the cycle after acceptance, gone after one take.
    a_single         = rand_a();
    a_single.address = 31'h4000_0000;
    a_single.data    = 64'hDEAD_BEEF_CAFE_F00D;
    a_single.mask    = 8'hFF;
    a_drv            = a_single;
    in_a_valid       = 1'b1;
    out_a_ready      = 1'b1;
    @(posedge clock); #1;
    in_a_valid = 1'b0;
    chk("single_out_a_valid", 128'(out_a_valid), 128'(1));
    chk("single_out_a_bits", 128'(a_mon), 128'(a_single));
    @(posedge clock); #1;
    chk("single_out_a_valid_drop", 128'(out_a_valid), 128'(0));

    // Streaming D: 100 beats back to back, consumer always ready.
    d_cnt0      = d_deq_cnt;
    gaps        = 0;
    in_d_ready  = 1'b1;
    out_d_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      d_drv        = rand_d();
      d_drv.source = 1'(i % 2);
      d_drv.data   = 64'(i);
      if (!out_d_ready) gaps++;
      @(posedge clock); #1;
      if (!in_d_valid) gaps++;
    end
    out_d_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("stream_gaps", 128'(gaps), 128'(0));
    chk("stream_count", 128'(d_deq_cnt - d_cnt0), 128'(100));

    // Enqueue and dequeue together at occupancy 1 across several pointer wraps.
    out_a_ready = 1'b0;
    in_a_valid  = 1'b1;
    a_drv       = rand_a();
    @(posedge clock); #1;
    out_a_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_drv = rand_a();
      @(posedge clock); #1;
      chk($sformatf("occ1_%0d_out_a_valid", i), 128'(out_a_valid), 128'(1));
      chk($sformatf("occ1_%0d_in_a_ready", i), 128'(in_a_ready), 128'(1));
    end
    in_a_valid = 1'b0;
    @(posedge clock); #1;
    chk("occ1_drained", 128'(out_a_valid), 128'(0));

    // Buffer two beats per channel, then assert reset between edges.
    out_a_ready = 1'b0;
    in_d_ready  = 1'b0;
    in_a_valid  = 1'b1;
    out_d_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_drv = rand_a();
      d_drv = rand_d();
      @(posedge clock); #1;
    end
    in_a_valid  = 1'b0;
    out_d_valid = 1'b0;
    chk("prereset_full_a", 128'(in_a_ready), 128'(0));
    chk("prereset_full_d", 128'(out_d_ready), 128'(0));
    #2 reset = 1'b0;
    #1;
    chk("async_out_a_valid", 128'(out_a_valid), 128'(0));
    chk("async_in_d_valid", 128'(in_d_valid), 128'(0));
    chk("async_in_a_ready", 128'(in_a_ready), 128'(1));
    chk("async_out_d_ready", 128'(out_d_ready), 128'(1));
    @(posedge clock); #3;
    reset       = 1'b1;
    out_a_ready = 1'b1;
    in_d_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      chk($sformatf("post_reset%0d_out_a_valid", i), 128'(out_a_valid), 128'(0));
      chk($sformatf("post_reset%0d_in_d_valid", i), 128'(in_d_valid), 128'(0));
    end

    chk("a_scoreboard_empty", 128'(a_q.size()), 128'(0));
    chk("d_scoreboard_empty", 128'(d_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
